// File: rtl/spi_cmd_pkg.sv
// ---------------------------------------------------------------------------
// spi_cmd_pkg
// Shared definitions for the SPI command controller: FSM state encoding,
// opcodes, register-map addresses, error codes and an address-decode helper.
// ---------------------------------------------------------------------------
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_CHK     = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_WAIT_CS = 3'd5
    } state_t;

    // Opcodes
    localparam logic [7:0] OP_WRITE   = 8'hA5;
    localparam logic [7:0] OP_CLR_ERR = 8'h5A;

    // Register map
    localparam logic [7:0] REG_DIGIT0 = 8'h00;  // digits occupy 0x00..0x03
    localparam logic [7:0] REG_FAN    = 8'h10;
    localparam logic [7:0] REG_CTRL   = 8'h11;

    // Error codes reported on oErrCode
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_OP   = 3'd1;
    localparam logic [2:0] ERR_BAD_ADDR = 3'd2;
    localparam logic [2:0] ERR_BAD_CHK  = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_CS_ABORT = 3'd5;

    // True for any address that maps onto a writable register.
    function automatic logic is_valid_addr(input logic [7:0] addr);
        return ((addr & 8'hFC) == REG_DIGIT0) || (addr == REG_FAN) || (addr == REG_CTRL);
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_cs_sync.sv
// ---------------------------------------------------------------------------
// cs_sync
// Two-flop synchronizer bringing the raw SPI chip select into the sysclk
// domain. Both flops clear to 0 on reset.
//
// Ports
//   clk_i   in   system clock
//   rst_ni  in   asynchronous active-low reset
//   d_i     in   asynchronous input
//   q_o     out  synchronized copy of d_i (2-cycle latency)
// ---------------------------------------------------------------------------
module cs_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// spi_cmd_ctrl
// Decodes 4-byte SPI command frames (CMD, ADDR, DATA, CHK with
// CHK = CMD ^ ADDR ^ DATA) into display / fan control registers, with
// error reporting for bad checksum, opcode, address, inter-byte timeout
// and chip-select abort.
//
// Ports
//   sysclk      in   system clock, rising edge
//   iRstN       in   async-assert active-low reset (released synchronously)
//   iRxReady    in   1-cycle strobe, iRx holds a received byte
//   iRx[7:0]    in   received byte
//   iSPICS      in   raw SPI chip select, active-low, asynchronous
//   digit0..3   out  display nibbles (registers 0x00..0x03)
//   oFanDuty    out  fan PWM duty (register 0x10)
//   oCtrl[1:0]  out  bit0 fan enable, bit1 display blank (register 0x11)
//   oCmdDone    out  1-cycle pulse after a successful commit
//   oErrCode    out  last error code
//   oErrCount   out  saturating error counter
// ---------------------------------------------------------------------------
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       sysclk,
    input  logic       iRstN,
    input  logic       iRxReady,
    input  logic [7:0] iRx,
    input  logic       iSPICS,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [7:0] oFanDuty,
    output logic [1:0] oCtrl,
    output logic       oCmdDone,
    output logic [2:0] oErrCode,
    output logic [7:0] oErrCount
);

    localparam logic [15:0] GAP_LIMIT = 16'(TIMEOUT_CYCLES);

    // Reset synchronizer: asserts immediately, releases on a clock edge so
    // no flop sees reset removal close to its active edge.
    logic rst_meta_q;
    logic rst_n_q;

    always_ff @(posedge sysclk or negedge iRstN) begin
        if (!iRstN) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    logic cs_sync_q;
    logic cs_active;

    cs_sync u_cs_sync (
        .clk_i  (sysclk),
        .rst_ni (rst_n_q),
        .d_i    (iSPICS),
        .q_o    (cs_sync_q)
    );

    assign cs_active = ~cs_sync_q;

    state_t          state_q,    state_d;
    logic [7:0]      cmd_q,      cmd_d;
    logic [7:0]      addr_q,     addr_d;
    logic [7:0]      data_q,     data_d;
    logic [7:0]      chk_q,      chk_d;
    logic [15:0]     gap_q,      gap_d;
    logic [3:0][3:0] digit_q,    digit_d;
    logic [7:0]      fan_q,      fan_d;
    logic [1:0]      ctrl_q,     ctrl_d;
    logic            done_q,     done_d;
    logic [2:0]      err_code_q, err_code_d;
    logic [7:0]      err_cnt_q,  err_cnt_d;

    logic            err_set;
    logic [2:0]      err_val;

    always_ff @(posedge sysclk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            gap_q      <= '0;
            digit_q    <= '0;
            fan_q      <= '0;
            ctrl_q     <= '0;
            done_q     <= 1'b0;
            err_code_q <= ERR_NONE;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            chk_q      <= chk_d;
            gap_q      <= gap_d;
            digit_q    <= digit_d;
            fan_q      <= fan_d;
            ctrl_q     <= ctrl_d;
            done_q     <= done_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        chk_d      = chk_q;
        gap_d      = gap_q;
        digit_d    = digit_q;
        fan_d      = fan_q;
        ctrl_d     = ctrl_q;
        done_d     = 1'b0;
        err_code_d = err_code_q;
        err_cnt_d  = err_cnt_q;
        err_set    = 1'b0;
        err_val    = ERR_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (iRxReady && cs_active) begin
                    cmd_d   = iRx;
                    gap_d   = '0;
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR, ST_DATA, ST_CHK: begin
                // CS abort wins over a byte arriving in the same cycle.
                if (!cs_active) begin
                    err_set = 1'b1;
                    err_val = ERR_CS_ABORT;
                    state_d = ST_IDLE;
                end else if (iRxReady) begin
                    gap_d = '0;
                    case (state_q)
                        ST_ADDR: begin
                            addr_d  = iRx;
                            state_d = ST_DATA;
                        end
                        ST_DATA: begin
                            data_d  = iRx;
                            state_d = ST_CHK;
                        end
                        default: begin
                            chk_d   = iRx;
                            state_d = ST_COMMIT;
                        end
                    endcase
                end else if (gap_q == GAP_LIMIT) begin
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                    state_d = ST_WAIT_CS;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            ST_COMMIT: begin
                state_d = ST_WAIT_CS;
                if (chk_q != (cmd_q ^ addr_q ^ data_q)) begin
                    err_set = 1'b1;
                    err_val = ERR_BAD_CHK;
                end else if (cmd_q == OP_CLR_ERR) begin
                    err_code_d = ERR_NONE;
                    err_cnt_d  = '0;
                    done_d     = 1'b1;
                end else if (cmd_q != OP_WRITE) begin
                    err_set = 1'b1;
                    err_val = ERR_BAD_OP;
                end else if (!is_valid_addr(addr_q)) begin
                    err_set = 1'b1;
                    err_val = ERR_BAD_ADDR;
                end else begin
                    if (addr_q == REG_FAN) begin
                        fan_d = data_q;
                    end else if (addr_q == REG_CTRL) begin
                        ctrl_d = data_q[1:0];
                    end else begin
                        digit_d[addr_q[1:0]] = data_q[3:0];
                    end
                    done_d = 1'b1;
                end
            end

            ST_WAIT_CS: begin
                // Trailing bytes are dropped until the master releases CS.
                if (!cs_active) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (err_set) begin
            err_code_d = err_val;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    assign digit0    = digit_q[0];
    assign digit1    = digit_q[1];
    assign digit2    = digit_q[2];
    assign digit3    = digit_q[3];
    assign oFanDuty  = fan_q;
    assign oCtrl     = ctrl_q;
    assign oCmdDone  = done_q;
    assign oErrCode  = err_code_q;
    assign oErrCount = err_cnt_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
module tb_spi_cmd_ctrl;

    localparam int TO = 40;

    logic       sysclk = 1'b0;
    logic       iRstN;
    logic       iRxReady;
    logic [7:0] iRx;
    logic       iSPICS;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [7:0] oFanDuty;
    logic [1:0] oCtrl;
    logic       oCmdDone;
    logic [2:0] oErrCode;
    logic [7:0] oErrCount;

    always #5 sysclk = ~sysclk;

    spi_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .sysclk    (sysclk),
        .iRstN     (iRstN),
        .iRxReady  (iRxReady),
        .iRx       (iRx),
        .iSPICS    (iSPICS),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .oFanDuty  (oFanDuty),
        .oCtrl     (oCtrl),
        .oCmdDone  (oCmdDone),
        .oErrCode  (oErrCode),
        .oErrCount (oErrCount)
    );

    typedef struct packed {
        logic [7:0]  fan;
        logic [1:0]  ctrl;
        logic [15:0] dig;
        logic [2:0]  code;
        logic [7:0]  cnt;
        logic [15:0] done;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Number of oCmdDone cycles seen; a multi-cycle pulse shows up here.
    logic [15:0] done_cnt = 16'd0;
    always @(negedge sysclk) begin
        if (oCmdDone === 1'b1) done_cnt <= done_cnt + 16'd1;
    end

    // Frame-level reference model.
    logic [7:0]  m_fan;
    logic [1:0]  m_ctrl;
    logic [15:0] m_dig;
    logic [2:0]  m_code;
    logic [7:0]  m_cnt;
    logic [15:0] m_done = 16'd0;

    task automatic model_reset();
        m_fan = 0; m_ctrl = 0; m_dig = 0; m_code = 0; m_cnt = 0;
    endtask

    task automatic model_err(input logic [2:0] c);
        m_code = c;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic model_frame(input logic [7:0] c, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] k);
        if (k != (c ^ a ^ d)) model_err(3'd3);
        else if (c == 8'h5A) begin
            m_code = 0; m_cnt = 0; m_done = m_done + 16'd1;
        end else if (c != 8'hA5) model_err(3'd1);
        else if (a == 8'h10) begin m_fan = d; m_done = m_done + 16'd1; end
        else if (a == 8'h11) begin m_ctrl = d[1:0]; m_done = m_done + 16'd1; end
        else if (a < 8'h04) begin m_dig[a[1:0]*4 +: 4] = d[3:0]; m_done = m_done + 16'd1; end
        else model_err(3'd2);
    endtask

    function automatic snap_t model_snap();
        return '{fan: m_fan, ctrl: m_ctrl, dig: m_dig, code: m_code, cnt: m_cnt, done: m_done};
    endfunction

    function automatic snap_t dut_snap();
        return '{fan: oFanDuty, ctrl: oCtrl, dig: {digit3, digit2, digit1, digit0},
                 code: oErrCode, cnt: oErrCount, done: done_cnt};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("fan=%h ctrl=%h dig=%h code=%0d cnt=%h done=%0d",
                         s.fan, s.ctrl, s.dig, s.code, s.cnt, s.done);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge sysclk); #1;
        iRx = b; iRxReady = 1'b1;
        @(posedge sysclk); #1;
        iRxReady = 1'b0;
    endtask

    task automatic cs_low();
        @(posedge sysclk); #1;
        iSPICS = 1'b0;
        repeat (3) @(posedge sysclk);
    endtask

    task automatic cs_high();
        iSPICS = 1'b1;
        repeat (4) @(posedge sysclk);
    endtask

    task automatic settle();
        repeat (4) @(negedge sysclk);
        #1;
    endtask

    task automatic frame_tx(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
        send_byte(c); send_byte(a); send_byte(d); send_byte(k);
        model_frame(c, a, d, k);
        exp_q.push_back(model_snap());
    endtask

    task automatic test_reset();
        iRstN = 1'b0; iRxReady = 1'b0; iRx = 8'h00; iSPICS = 1'b1;
        repeat (3) @(negedge sysclk);
        checks++; if (oFanDuty !== 8'h00) begin errors++; $display("FAIL reset_fan: got %h want 00", oFanDuty); end
        checks++; if (oCtrl !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b want 00", oCtrl); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin errors++;
            $display("FAIL reset_digits: got %h want 0000", {digit3, digit2, digit1, digit0}); end
        checks++; if (oCmdDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", oCmdDone); end
        checks++; if (oErrCode !== 3'd0) begin errors++; $display("FAIL reset_errcode: got %0d want 0", oErrCode); end
        checks++; if (oErrCount !== 8'h00) begin errors++; $display("FAIL reset_errcount: got %h want 00", oErrCount); end
        @(posedge sysclk); #1;
        iRstN = 1'b1;
        repeat (6) @(posedge sysclk);
        model_reset();
    endtask

    task automatic test_fan();
        snap_t o, e;
        int lat;
        cs_low();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h80); send_byte(8'h35);
        model_frame(8'hA5, 8'h10, 8'h80, 8'h35);
        exp_q.push_back(model_snap());
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            if (oCmdDone === 1'b1) begin lat = i; break; end
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL fan_done_latency: got %0d want 1", lat); end
        settle();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL fan_frame: got %s want %s", fmt(o), fmt(e)); end
        checks++; if (oFanDuty !== 8'h80) begin errors++; $display("FAIL fan_value: got %h want 80", oFanDuty); end
        checks++; if (oErrCode !== 3'd0) begin errors++; $display("FAIL fan_errcode: got %0d want 0", oErrCode); end
        cs_high();
    endtask

    task automatic test_digit();
        snap_t o, e;
        cs_low(); frame_tx(8'hA5, 8'h00, 8'h03, 8'hA6); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL digit0_frame: got %s want %s", fmt(o), fmt(e)); end
        cs_low(); frame_tx(8'hA5, 8'h02, 8'h07, 8'hA0); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL digit2_frame: got %s want %s", fmt(o), fmt(e)); end
        checks++; if ({digit3, digit2, digit1, digit0} !== 16'h0703) begin errors++;
            $display("FAIL digit2_value: got %h want 0703", {digit3, digit2, digit1, digit0}); end
    endtask

    task automatic test_ctrl();
        snap_t o, e;
        cs_low(); frame_tx(8'hA5, 8'h11, 8'h03, 8'hB7); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL ctrl_frame: got %s want %s", fmt(o), fmt(e)); end
        checks++; if (oCtrl !== 2'b11) begin errors++; $display("FAIL ctrl_value: got %b want 11", oCtrl); end
    endtask

    task automatic test_idle_ignore();
        snap_t o, e;
        exp_q.push_back(model_snap());
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h55); send_byte(8'hE0);
        settle();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL idle_ignore: got %s want %s", fmt(o), fmt(e)); end
    endtask

    task automatic test_errors();
        snap_t o, e;
        cs_low(); frame_tx(8'hA5, 8'h10, 8'h80, 8'h00); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL bad_chk: got %s want %s", fmt(o), fmt(e)); end
        checks++; if ({oErrCode, oErrCount, oFanDuty} !== {3'd3, 8'h01, 8'h80}) begin errors++;
            $display("FAIL bad_chk_values: got code=%0d cnt=%h fan=%h want code=3 cnt=01 fan=80", oErrCode, oErrCount, oFanDuty); end
        cs_low(); frame_tx(8'h33, 8'h10, 8'h80, 8'hA3); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL bad_opcode: got %s want %s", fmt(o), fmt(e)); end
        cs_low(); frame_tx(8'hA5, 8'h20, 8'h01, 8'h84); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL bad_addr: got %s want %s", fmt(o), fmt(e)); end
        checks++; if (oErrCode !== 3'd2) begin errors++; $display("FAIL bad_addr_code: got %0d want 2", oErrCode); end
    endtask

    task automatic test_timeout();
        snap_t o, e;
        int lat;
        cs_low();
        send_byte(8'hA5); send_byte(8'h10);
        lat = -1;
        for (int i = 0; i < TO + 20; i++) begin
            @(negedge sysclk);
            if (oErrCode === 3'd4) begin lat = i; break; end
        end
        checks++; if (lat !== TO + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 1); end
        model_err(3'd4);
        exp_q.push_back(model_snap());
        send_byte(8'h80); send_byte(8'h35);
        settle();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL timeout_ignore: got %s want %s", fmt(o), fmt(e)); end
        cs_high();
    endtask

    task automatic test_cs_abort();
        snap_t o, e;
        cs_low();
        send_byte(8'hA5); send_byte(8'h10);
        iSPICS = 1'b1;
        @(posedge sysclk); #1;
        @(posedge sysclk); #1;
        iRx = 8'h44; iRxReady = 1'b1;
        @(posedge sysclk); #1;
        iRxReady = 1'b0;
        model_err(3'd5);
        exp_q.push_back(model_snap());
        settle();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL cs_abort: got %s want %s", fmt(o), fmt(e)); end
        checks++; if (oErrCode !== 3'd5) begin errors++; $display("FAIL cs_abort_code: got %0d want 5", oErrCode); end
        repeat (2) @(posedge sysclk);
        cs_low(); frame_tx(8'hA5, 8'h10, 8'h44, 8'hF1); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL after_abort_frame: got %s want %s", fmt(o), fmt(e)); end
        checks++; if (oFanDuty !== 8'h44) begin errors++; $display("FAIL after_abort_fan: got %h want 44", oFanDuty); end
    endtask

    task automatic test_clear();
        snap_t o, e;
        cs_low(); frame_tx(8'h5A, 8'h00, 8'h00, 8'h5A); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL clear_frame: got %s want %s", fmt(o), fmt(e)); end
        checks++; if ({oErrCode, oErrCount} !== {3'd0, 8'h00}) begin errors++;
            $display("FAIL clear_values: got code=%0d cnt=%h want code=0 cnt=00", oErrCode, oErrCount); end
    endtask

    task automatic test_saturate();
        snap_t o, e;
        for (int i = 0; i < 256; i++) begin
            cs_low();
            send_byte(8'hA5); send_byte(8'h10); send_byte(8'h80); send_byte(8'h00);
            model_frame(8'hA5, 8'h10, 8'h80, 8'h00);
            settle();
            cs_high();
        end
        exp_q.push_back(model_snap());
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL saturate: got %s want %s", fmt(o), fmt(e)); end
        checks++; if (oErrCount !== 8'hFF) begin errors++; $display("FAIL saturate_count: got %h want FF", oErrCount); end
    endtask

    task automatic test_back_to_back();
        snap_t obs[2];
        snap_t e;
        cs_low(); frame_tx(8'hA5, 8'h01, 8'h09, 8'hAD); settle(); cs_high();
        obs[0] = dut_snap();
        cs_low(); frame_tx(8'hA5, 8'h03, 8'h0F, 8'hA9); settle(); cs_high();
        obs[1] = dut_snap();
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++; if (obs[i] !== e) begin errors++;
                $display("FAIL back_to_back_%0d: got %s want %s", i, fmt(obs[i]), fmt(e)); end
        end
    endtask

    task automatic test_reset_midframe();
        snap_t o, e;
        cs_low();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h80);
        iRstN = 1'b0;
        iSPICS = 1'b1;
        repeat (2) @(posedge sysclk); #1;
        iRstN = 1'b1;
        repeat (6) @(posedge sysclk);
        model_reset();
        exp_q.push_back(model_snap());
        settle();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL reset_midframe: got %s want %s", fmt(o), fmt(e)); end
        cs_low(); frame_tx(8'hA5, 8'h10, 8'h80, 8'h35); settle(); cs_high();
        o = dut_snap(); e = exp_q.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL after_reset_frame: got %s want %s", fmt(o), fmt(e)); end
    endtask

    initial begin
        test_reset();
        test_fan();
        test_digit();
        test_ctrl();
        test_idle_ignore();
        test_errors();
        test_timeout();
        test_cs_abort();
        test_clear();
        test_saturate();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, which is the maximum sysclk cycles allowed between bytes of one frame.
REQ-002 SHALL have port sysclk  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port iRstN  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port iRxReady  in  1  single-cycle pulse: a received SPI byte is valid on iRx.
REQ-005 SHALL have port iRx  in  8  received byte.
REQ-006 SHALL have port iSPICS  in  1  raw SPI chip select, active-low and asynchronous to sysclk.
REQ-007 SHALL have ports digit0, digit1, digit2, digit3  out  4 each  display nibbles.
REQ-008 SHALL have port oFanDuty  out  8  fan PWM duty.
REQ-009 SHALL have port oCtrl  out  2  bit0 fan enable, bit1 display blank.
REQ-010 SHALL have port oCmdDone  out  1  single-cycle pulse on a successful commit.
REQ-011 SHALL have port oErrCode  out  3  last error code; 0 none, 1 bad opcode, 2 bad address, 3 bad checksum, 4 timeout, 5 CS abort.
REQ-012 SHALL have port oErrCount  out  8  saturating error counter.

Function
REQ-013 SHALL pass iSPICS through a 2-flop synchronizer; csActive = synchronized iSPICS low.
REQ-014 SHALL use the frame format CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA.
REQ-015 SHALL implement the FSM states IDLE, ADDR, DATA, CHK, COMMIT, WAIT_CS.
- IDLE: on iRxReady with csActive, latch CMD and go to ADDR.
- ADDR/DATA/CHK: latch the byte on iRxReady and advance.
- COMMIT: lasts 1 cycle, then goes to WAIT_CS.
REQ-016 SHALL, in COMMIT, check in priority order checksum (error 3), then opcode (error 1), then address (error 2).
REQ-017 SHALL accept opcode 0xA5 (write register) and opcode 0x5A (clear oErrCount; ADDR and DATA are ignored).
REQ-018 SHALL use this register map: 0x00-0x03 map to digit0-3 from DATA[3:0], 0x10 maps to oFanDuty, 0x11 maps to oCtrl from DATA[1:0].
REQ-019 SHALL, on a valid commit, update the target register and pulse oCmdDone in the cycle after COMMIT (latency: 2 cycles from the CHK iRxReady).
REQ-020 SHALL ignore all bytes in WAIT_CS, return to IDLE when csActive falls, and never commit extra bytes.
REQ-021 SHALL restart a 16-bit gap counter on each accepted byte while in ADDR, DATA or CHK.
REQ-022 SHALL, when the gap counter reaches TIMEOUT_CYCLES, set error 4 and go to WAIT_CS.
REQ-023 SHALL, if csActive falls in ADDR, DATA or CHK, set error 5 and go to IDLE.
REQ-024 SHALL give CS abort priority over an iRxReady in the same cycle, and discard that byte.
REQ-025 SHALL, on any error, set oErrCode, increment oErrCount saturating at 0xFF, and leave registers unchanged.
REQ-026 SHALL leave oErrCode unchanged on a successful commit; it is cleared only by opcode 0x5A or reset.
REQ-027 SHALL ignore iRxReady while not csActive in IDLE.

Reset
REQ-028 SHALL, while iRstN is low, force the FSM to IDLE and all outputs, latched bytes, counters and synchronizer flops to 0.
REQ-029 SHALL, on reset mid-frame, discard the partial frame with no commit and no error count.
REQ-030 SHALL release reset synchronously to sysclk.

Structure
REQ-031 SHALL place the opcodes, register addresses, error codes and FSM state encoding in a shared package, spi_cmd_pkg.
REQ-032 SHALL instantiate one sub-module, cs_sync, which is the 2-flop synchronizer.

Verification
REQ-033 SHALL cover: frame A5,10,80,35 -> oFanDuty=0x80, oCmdDone one pulse, oErrCode=0.
REQ-034 SHALL cover: frame A5,02,07,A0 -> digit2=7, other digits unchanged.
REQ-035 SHALL cover: frame A5,10,80,00 -> oErrCode=3, oErrCount=1, oFanDuty unchanged.
REQ-036 SHALL cover: A5,10 then no byte for TIMEOUT_CYCLES -> oErrCode=4, and a following byte is ignored until CS deasserts.
REQ-037 SHALL cover: CS raised after A5,10 together with an iRxReady -> oErrCode=5, the byte is discarded, and the FSM is in IDLE.
REQ-038 SHALL cover: after errors, frame 5A,00,00,5A -> oErrCount=0 and oErrCode=0; also 256 bad frames -> oErrCount=0xFF.
